// File: rtl/instruction_fetch_pkg.sv
// Purpose : shared constants and types for the instruction fetch stage.
//   XLEN_DEFAULT         default datapath / PC width
//   RESET_VECTOR_DEFAULT PC value after reset
//   NOP_INST             instruction presented to decode after reset (addi x0,x0,0)
//   fetch_state_e        fetch FSM state encoding
package instruction_fetch_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST             = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Purpose : instruction memory request/response bundle.
//   imem_req   fetch unit -> memory  request, held until acknowledged
//   imem_addr  fetch unit -> memory  word-aligned fetch address
//   imem_ack   memory -> fetch unit  response valid (meaningful only while imem_req=1)
//   imem_rdata memory -> fetch unit  instruction word, valid with imem_ack
// Modports: master = fetch unit side, slave = memory side.
interface instruction_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_obuf.sv
// Purpose : enabled output register with asynchronous active-low reset to a
//           parameterised value.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (loads RST_VAL)
//   i_en     load enable
//   i_d      data in
//   o_q      registered data out
module instruction_fetch_obuf #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/instruction_fetch.sv
// Purpose : single-outstanding instruction fetch stage. A phase_fetch pulse in
//           IDLE issues one memory request at the current PC; the acknowledged
//           word is registered towards decode together with its address.
//   clk               CPU clock (rising edge)
//   rst_n             asynchronous active-low reset
//   phase_fetch       pulse: start one fetch (ignored while busy)
//   pc_update         pulse: load pc_target (low two bits forced to zero)
//   pc_target         redirect target
//   imem              instruction memory bundle (master side)
//   inst              fetched instruction word
//   curr_pc_fd        address of inst
//   next_pc_fd        curr_pc_fd + 4
//   stall_fetch       high while a fetch is outstanding
//   target_misaligned sticky: a redirect target with bits[1:0] != 0 was seen
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 phase_fetch,
    input  logic                 pc_update,
    input  logic [XLEN-1:0]      pc_target,
    instruction_fetch_if.master  imem,
    output logic [31:0]          inst,
    output logic [XLEN-1:0]      curr_pc_fd,
    output logic [XLEN-1:0]      next_pc_fd,
    output logic                 stall_fetch,
    output logic                 target_misaligned
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            w_start;
    logic            w_capture;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr;
    logic            r_redirect;
    logic            r_misaligned;
    logic [XLEN-1:0] w_target_aligned;
    logic [XLEN-1:0] w_addr_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (phase_fetch) begin
                    w_state_next = BUSY;
                    w_start      = 1'b1;
                end
            end
            BUSY: begin
                if (imem.imem_ack) begin
                    w_state_next = IDLE;
                    w_capture    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_target_aligned = {pc_target[XLEN-1:2], 2'b00};
    assign w_addr_plus4     = r_addr + PC_STEP;

    // The request address is latched separately from the PC so a redirect
    // while busy leaves the outstanding request (and its captured address)
    // untouched. r_redirect remembers such a redirect so the ack does not
    // advance the new target by 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_addr       <= RESET_VECTOR;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr <= r_pc;
            end

            if (pc_update) begin
                r_pc <= w_target_aligned;
            end else if (w_capture && !r_redirect) begin
                r_pc <= r_pc + PC_STEP;
            end

            r_redirect <= (w_state_next == BUSY) && (r_redirect || pc_update);

            if (pc_update && (pc_target[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = (r_state == BUSY);
    assign imem.imem_addr = r_addr;
    assign stall_fetch    = (r_state == BUSY);
    assign target_misaligned = r_misaligned;

    instruction_fetch_obuf #(
        .W       (32),
        .RST_VAL (NOP_INST)
    ) u_obuf_inst (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_capture),
        .i_d     (imem.imem_rdata),
        .o_q     (inst)
    );

    instruction_fetch_obuf #(
        .W       (XLEN),
        .RST_VAL (RESET_VECTOR)
    ) u_obuf_curr_pc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_capture),
        .i_d     (r_addr),
        .o_q     (curr_pc_fd)
    );

    instruction_fetch_obuf #(
        .W       (XLEN),
        .RST_VAL (RESET_VECTOR + PC_STEP)
    ) u_obuf_next_pc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_capture),
        .i_d     (w_addr_plus4),
        .o_q     (next_pc_fd)
    );
endmodule
